// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants and types for the byte-wide memory arbiter.
//   ADDR_WIDTH_DEF : default cache/RAM byte address width
//   IO_TAG         : top two address bits that select IO space
//   gnt_e          : which master owns the RAM port this cycle
package mem_ctrl_pkg;
  localparam int ADDR_WIDTH_DEF = 18;
  localparam logic [1:0] IO_TAG = 2'b11;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_D    = 2'd1,
    GNT_I    = 2'd2
  } gnt_e;
endpackage

// File: rtl/mem_stat_counter.sv
// mem_stat_counter: saturating event counter.
//   clk, rst : clock, synchronous active-high clear
//   inc      : count one event this cycle
//   cnt      : current count, sticks at all-ones
module mem_stat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole master of the external RAM/IO port, arbitrating byte
// requests from dcache (fixed high priority) and icache.
//   clk, rst             : clock, synchronous active-high reset
//   io_buffer_full       : IO write buffer cannot take another byte
//   dcache_*             : dcache byte request (read/write), ack and read data
//   icache_*             : icache byte read request, ack and read data
//   ram_din/addr/dout/wr : external RAM/IO port, read data one cycle after addr
// Optional: define MEM_CTRL_STATS_EN to add saturating grant/stall counters
// (stat_dcache_grants, stat_icache_grants, stat_icache_stalls).
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
`ifdef MEM_CTRL_STATS_EN
  , parameter int STAT_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  io_buffer_full,
  input  logic                  dcache_get_en,
  input  logic                  dcache_write_mode,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [7:0]            dcache_data,
  output logic                  dcache_out_en,
  output logic [7:0]            dcache_content,
  input  logic                  icache_get_en,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_out_en,
  output logic [7:0]            icache_content,
  input  logic [7:0]            ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr
`ifdef MEM_CTRL_STATS_EN
  , output logic [STAT_WIDTH-1:0] stat_dcache_grants
  , output logic [STAT_WIDTH-1:0] stat_icache_grants
  , output logic [STAT_WIDTH-1:0] stat_icache_stalls
`endif
);
  gnt_e gnt;
  logic d_ok;
  logic d_ack_q, d_ack_d;
  logic i_ack_q, i_ack_d;

  // IO writes are held off while the IO buffer is full; the slot is then
  // free for icache rather than wasted.
  always_comb begin
    d_ok = dcache_get_en &&
           !(dcache_write_mode && (dcache_addr[ADDR_WIDTH-1 -: 2] == IO_TAG) &&
             io_buffer_full);
    gnt = GNT_NONE;
    if (d_ok)               gnt = GNT_D;
    else if (icache_get_en) gnt = GNT_I;
  end

  // Idle port drives address 0 so no IO register sees a side-effecting read.
  always_comb begin
    ram_addr = '0;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    case (gnt)
      GNT_D: begin
        ram_addr = dcache_addr;
        ram_wr   = dcache_write_mode;
        ram_dout = dcache_data;
      end
      GNT_I: ram_addr = icache_addr;
      default: ;
    endcase
  end

  always_comb begin
    d_ack_d = (gnt == GNT_D);
    i_ack_d = (gnt == GNT_I);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_ack_q <= 1'b0;
      i_ack_q <= 1'b0;
    end else begin
      d_ack_q <= d_ack_d;
      i_ack_q <= i_ack_d;
    end
  end

  assign dcache_out_en = d_ack_q;
  assign icache_out_en = i_ack_q;

  // Unregistered on purpose: dcache samples IO read data in the ack cycle.
  assign dcache_content = ram_din;
  assign icache_content = ram_din;

`ifdef MEM_CTRL_STATS_EN
  mem_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_d (
    .clk(clk), .rst(rst), .inc(gnt == GNT_D), .cnt(stat_dcache_grants));
  mem_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_i (
    .clk(clk), .rst(rst), .inc(gnt == GNT_I), .cnt(stat_icache_grants));
  mem_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_s (
    .clk(clk), .rst(rst), .inc(icache_get_en && (gnt == GNT_D)),
    .cnt(stat_icache_stalls));
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven check of mem_ctrl with an ack scoreboard,
// plus hand-written sequences for icache starvation and (optionally) stats.
module tb_mem_ctrl;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          io_buffer_full;
  logic          dcache_get_en, dcache_write_mode;
  logic [AW-1:0] dcache_addr;
  logic [7:0]    dcache_data;
  logic          dcache_out_en;
  logic [7:0]    dcache_content;
  logic          icache_get_en;
  logic [AW-1:0] icache_addr;
  logic          icache_out_en;
  logic [7:0]    icache_content;
  logic [7:0]    ram_din;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic          ram_wr;
`ifdef MEM_CTRL_STATS_EN
  logic [31:0]   stat_dcache_grants, stat_icache_grants, stat_icache_stalls;
`endif

  mem_ctrl dut (
    .clk(clk), .rst(rst), .io_buffer_full(io_buffer_full),
    .dcache_get_en(dcache_get_en), .dcache_write_mode(dcache_write_mode),
    .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .dcache_out_en(dcache_out_en), .dcache_content(dcache_content),
    .icache_get_en(icache_get_en), .icache_addr(icache_addr),
    .icache_out_en(icache_out_en), .icache_content(icache_content),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr)
`ifdef MEM_CTRL_STATS_EN
    , .stat_dcache_grants(stat_dcache_grants)
    , .stat_icache_grants(stat_icache_grants)
    , .stat_icache_stalls(stat_icache_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, full, dg, dw;
    logic [AW-1:0] da;
    logic [7:0]    dd;
    logic          ig;
    logic [AW-1:0] ia;
    logic [7:0]    din;
    logic [AW-1:0] ea;   // expected ram_addr
    logic          ewr;  // expected ram_wr
    logic [7:0]    edo;  // expected ram_dout
    logic [1:0]    eg;   // expected grant: 0 none, 1 dcache, 2 icache
  } vec_t;

  typedef struct { logic d; logic i; } ack_t;

  vec_t v[$];
  ack_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic r, logic f, logic dg, logic dw, logic [AW-1:0] da,
                              logic [7:0] dd, logic ig, logic [AW-1:0] ia, logic [7:0] din,
                              logic [AW-1:0] ea, logic ewr, logic [7:0] edo, logic [1:0] eg);
    vec_t t;
    t.rst = r; t.full = f; t.dg = dg; t.dw = dw; t.da = da; t.dd = dd;
    t.ig = ig; t.ia = ia; t.din = din; t.ea = ea; t.ewr = ewr; t.edo = edo; t.eg = eg;
    return t;
  endfunction

  task automatic drive_idle();
    io_buffer_full = 0; dcache_get_en = 0; dcache_write_mode = 0;
    dcache_addr = '0; dcache_data = 8'h00; icache_get_en = 0; icache_addr = '0;
    ram_din = 8'h00;
  endtask

  initial begin
    ack_t e;
    ack_t n;
    bit   seen;
    //        rst f dg dw da        dd     ig ia       din    ea        wr do     g
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h00, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,1,18'h00010,8'h00, 18'h00010,0,8'h00,2));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h5A, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,0,1,0,18'h00100,8'h00,1,18'h00020,8'h00, 18'h00100,0,8'h00,1));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,1,18'h00020,8'hC3, 18'h00020,0,8'h00,2));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h96, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,0,1,1,18'h00200,8'h11,0,18'h00000,8'h00, 18'h00200,1,8'h11,1));
    v.push_back(mk(0,0,1,1,18'h00201,8'h22,0,18'h00000,8'h00, 18'h00201,1,8'h22,1));
    v.push_back(mk(0,0,1,1,18'h00202,8'h33,0,18'h00000,8'h00, 18'h00202,1,8'h33,1));
    v.push_back(mk(0,0,1,1,18'h00203,8'h44,0,18'h00000,8'h00, 18'h00203,1,8'h44,1));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h00, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,1,1,1,18'h30000,8'hAB,1,18'h00040,8'h00, 18'h00040,0,8'h00,2));
    v.push_back(mk(0,0,1,1,18'h30000,8'hAB,0,18'h00000,8'h00, 18'h30000,1,8'hAB,1));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h00, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,1,1,1,18'h30000,8'hCD,0,18'h00000,8'h00, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,1,1,0,18'h30001,8'h00,0,18'h00000,8'h00, 18'h30001,0,8'h00,1));
    v.push_back(mk(0,1,0,0,18'h00000,8'h00,0,18'h00000,8'h7E, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,1,1,1,18'h20000,8'h55,0,18'h00000,8'h00, 18'h20000,1,8'h55,1));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h00, 18'h00000,0,8'h00,0));
    v.push_back(mk(0,0,1,0,18'h00060,8'h00,1,18'h00050,8'h00, 18'h00060,0,8'h00,1));
    v.push_back(mk(0,0,1,0,18'h00061,8'h00,1,18'h00050,8'hE1, 18'h00061,0,8'h00,1));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,1,18'h00050,8'hE2, 18'h00050,0,8'h00,2));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h3C, 18'h00000,0,8'h00,0));
    // reset lands in the same cycle as a dcache grant: the ack must be dropped
    v.push_back(mk(1,0,1,0,18'h00070,8'h00,0,18'h00000,8'h00, 18'h00070,0,8'h00,1));
    v.push_back(mk(0,0,0,0,18'h00000,8'h00,0,18'h00000,8'h00, 18'h00000,0,8'h00,0));

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n.d = 0; n.i = 0;
    sb.push_back(n);

    for (int k = 0; k < v.size(); k++) begin
      @(posedge clk); #1;
      rst = v[k].rst; io_buffer_full = v[k].full;
      dcache_get_en = v[k].dg; dcache_write_mode = v[k].dw;
      dcache_addr = v[k].da; dcache_data = v[k].dd;
      icache_get_en = v[k].ig; icache_addr = v[k].ia; ram_din = v[k].din;
      @(negedge clk);
      chk("ram_addr", 32'(ram_addr), 32'(v[k].ea));
      chk("ram_wr",   32'(ram_wr),   32'(v[k].ewr));
      chk("ram_dout", 32'(ram_dout), 32'(v[k].edo));
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty: vector %0d had no expected ack", k);
      end else begin
        e = sb.pop_front();
        chk("dcache_out_en", 32'(dcache_out_en), 32'(e.d));
        chk("icache_out_en", 32'(icache_out_en), 32'(e.i));
        if (e.d) chk("dcache_content", 32'(dcache_content), 32'(v[k].din));
        if (e.i) chk("icache_content", 32'(icache_content), 32'(v[k].din));
      end
      n.d = !v[k].rst && (v[k].eg == 2'd1);
      n.i = !v[k].rst && (v[k].eg == 2'd2);
      sb.push_back(n);
    end

    // icache starves for as long as dcache keeps requesting
    @(posedge clk); #1;
    drive_idle();
    dcache_get_en = 1; dcache_addr = 18'h00400;
    icache_get_en = 1; icache_addr = 18'h00080;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (icache_out_en) seen = 1;
      @(posedge clk); #1;
      dcache_addr = dcache_addr + 1'b1;
    end
    chk("icache_starved", 32'(seen), 32'd0);
    dcache_get_en = 0;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (icache_out_en) seen = 1;
      @(posedge clk); #1;
    end
    chk("icache_regrant", 32'(seen), 32'd1);
    drive_idle();

`ifdef MEM_CTRL_STATS_EN
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("stat_d_reset", stat_dcache_grants, 32'd0);
    @(posedge clk); #1;
    dcache_get_en = 1; dcache_addr = 18'h00500;
    @(posedge clk); #1;
    icache_get_en = 1; icache_addr = 18'h00090;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dcache_get_en = 0;
    @(posedge clk); #1;
    icache_get_en = 0;
    @(negedge clk);
    chk("stat_dcache_grants", stat_dcache_grants, 32'd3);
    chk("stat_icache_stalls", stat_icache_stalls, 32'd2);
    chk("stat_icache_grants", stat_icache_grants, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
